// File: rtl/ppi_pkg.sv
// Shared definitions for the strobed PPI port.
//   ppi_mode_t : 2-bit port mode. Bit 1 selects strobed (Mode 1) operation,
//                bit 0 selects the output direction.
package ppi_pkg;

    typedef enum logic [1:0] {
        MODE0_IN  = 2'b00,
        MODE0_OUT = 2'b01,
        MODE1_IN  = 2'b10,
        MODE1_OUT = 2'b11
    } ppi_mode_t;

    function automatic logic is_output(ppi_mode_t m);
        return m[0];
    endfunction

endpackage

// File: rtl/ppi_sync_edge.sv
// Synchroniser plus edge detector for one asynchronous handshake pin.
//   clk, rst : clock, synchronous active-high reset
//   din      : asynchronous pin
//   fall     : one-cycle pulse, SYNC_STAGES+1 cycles after a high->low pin edge
//   rise     : one-cycle pulse, SYNC_STAGES+1 cycles after a low->high pin edge
module ppi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // vld_pipe[i] marks that sync_q[i] (or prev_q for i=SYNC_STAGES) holds a
    // real post-reset sample. Edges are only reported between two real
    // samples, so a pin held low through reset never looks like a fall.
    logic [SYNC_STAGES:0]   vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            prev_q   <= RESET_VAL;
            vld_pipe <= '0;
            fall     <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q   <= sync_q[SYNC_STAGES-1];
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            fall     <= vld_pipe[SYNC_STAGES] &  prev_q & ~sync_q[SYNC_STAGES-1];
            rise     <= vld_pipe[SYNC_STAGES] & ~prev_q &  sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/ppi_strobed_port.sv
// Single 8255A-style port: Mode 0 basic I/O and Mode 1 strobed I/O.
//   clk, rst          : clock, synchronous active-high reset
//   mode, inte        : port mode (ppi_mode_t encoding), interrupt enable
//   bus_wr, bus_wdata : one-cycle write strobe and data
//   bus_rd, bus_rdata : one-cycle read acknowledge, combinational read data
//   px_in/out/oe      : pin side; pads are tri-stated by the parent from px_oe
//   stb_n, ack_n      : asynchronous Mode 1 input strobe / output acknowledge
//   ibf, obf_n, intr, ovr : handshake, interrupt and sticky overrun flags
module ppi_strobed_port
    import ppi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             inte,
    input  logic             bus_wr,
    input  logic [WIDTH-1:0] bus_wdata,
    input  logic             bus_rd,
    output logic [WIDTH-1:0] bus_rdata,
    input  logic [WIDTH-1:0] px_in,
    output logic [WIDTH-1:0] px_out,
    output logic             px_oe,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             ovr
);

    ppi_mode_t        mode_q;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] in_latch;
    logic             rst_done;
    logic             stb_fall, stb_rise, ack_fall, ack_rise;

    ppi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_stb_sync (
        .clk (clk), .rst (rst), .din (stb_n), .fall (stb_fall), .rise (stb_rise)
    );

    ppi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ack_sync (
        .clk (clk), .rst (rst), .din (ack_n), .fall (ack_fall), .rise (ack_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= ppi_mode_t'(mode);
            out_reg  <= '0;
            in_latch <= '0;
            ibf      <= 1'b0;
            obf_n    <= 1'b1;
            intr     <= 1'b0;
            ovr      <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (ppi_mode_t'(mode) != mode_q) begin
                // Mode switch: flush the port, ignore every other event.
                mode_q  <= ppi_mode_t'(mode);
                out_reg <= '0;
                ibf     <= 1'b0;
                obf_n   <= 1'b1;
                intr    <= 1'b0;
                ovr     <= 1'b0;
            end else begin
                case (mode_q)
                    MODE0_OUT: begin
                        if (bus_wr) out_reg <= bus_wdata;
                    end
                    MODE1_IN: begin
                        if (bus_rd) begin
                            ibf  <= 1'b0;
                            intr <= 1'b0;
                            ovr  <= 1'b0;
                        end
                        // A read in the same cycle empties the buffer first,
                        // so the strobe loads instead of overrunning.
                        if (stb_fall) begin
                            if (!ibf || bus_rd) begin
                                in_latch <= px_in;
                                ibf      <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end
                        if (stb_rise && ibf && inte && !bus_rd) intr <= 1'b1;
                        if (!inte) intr <= 1'b0;
                    end
                    MODE1_OUT: begin
                        if (ack_fall) obf_n <= 1'b1;
                        if (ack_rise && obf_n && inte) intr <= 1'b1;
                        if (!inte) intr <= 1'b0;
                        // The write is last so it beats a coincident ack.
                        if (bus_wr) begin
                            out_reg <= bus_wdata;
                            obf_n   <= 1'b0;
                            intr    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus_rdata = out_reg;
        case (mode_q)
            MODE0_IN: bus_rdata = px_in;
            MODE1_IN: bus_rdata = in_latch;
            default:  bus_rdata = out_reg;
        endcase
    end

    assign px_out = out_reg;
    // Held off until the first edge after reset release.
    assign px_oe  = rst_done & is_output(mode_q);

endmodule

// File: tb/tb_ppi_strobed_port.sv
module tb_ppi_strobed_port;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int L     = SYNC + 2;  // pin edge to visible flag, in cycles

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             inte;
    logic             bus_wr;
    logic [WIDTH-1:0] bus_wdata;
    logic             bus_rd;
    logic [WIDTH-1:0] bus_rdata;
    logic [WIDTH-1:0] px_in;
    logic [WIDTH-1:0] px_out;
    logic             px_oe;
    logic             stb_n;
    logic             ack_n;
    logic             ibf, obf_n, intr, ovr;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the port as seen from the bus and pins.
    logic [1:0]       m_mode;
    logic [WIDTH-1:0] m_out, m_latch;
    logic             m_ibf, m_obf_n, m_intr, m_ovr;

    ppi_strobed_port #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk (clk), .rst (rst), .mode (mode), .inte (inte),
        .bus_wr (bus_wr), .bus_wdata (bus_wdata), .bus_rd (bus_rd), .bus_rdata (bus_rdata),
        .px_in (px_in), .px_out (px_out), .px_oe (px_oe),
        .stb_n (stb_n), .ack_n (ack_n),
        .ibf (ibf), .obf_n (obf_n), .intr (intr), .ovr (ovr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rdata();
        if (m_mode == 2'b00) return px_in;
        if (m_mode == 2'b10) return m_latch;
        return m_out;
    endfunction

    task automatic check_all(input string tag);
        chk1({tag, ".ibf"},   ibf,   m_ibf);
        chk1({tag, ".obf_n"}, obf_n, m_obf_n);
        chk1({tag, ".intr"},  intr,  m_intr);
        chk1({tag, ".ovr"},   ovr,   m_ovr);
        chk8({tag, ".px_out"}, px_out, m_out);
        chk1({tag, ".px_oe"}, px_oe, m_mode[0]);
        chk8({tag, ".rdata"}, bus_rdata, exp_rdata());
    endtask

    task automatic model_flush();
        m_out = '0; m_ibf = 1'b0; m_obf_n = 1'b1; m_intr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        tick();
        if (m != m_mode) begin
            m_mode = m;
            model_flush();
        end
        if (!inte && m_mode[1]) m_intr = 1'b0;
    endtask

    task automatic do_write(input logic [WIDTH-1:0] d);
        bus_wr = 1'b1; bus_wdata = d;
        tick();
        bus_wr = 1'b0;
        if (m_mode[0]) m_out = d;
        if (m_mode == 2'b11) begin m_obf_n = 1'b0; m_intr = 1'b0; end
    endtask

    task automatic do_read();
        bus_rd = 1'b1;
        #1;
        chk8("read.rdata", bus_rdata, exp_rdata());
        tick();
        bus_rd = 1'b0;
        if (m_mode == 2'b10) begin m_ibf = 1'b0; m_intr = 1'b0; m_ovr = 1'b0; end
    endtask

    // Full strobe pulse, low for w >= L cycles; data changes only after the hold window.
    task automatic stb_pulse(input int w, input logic [WIDTH-1:0] d);
        px_in = d;
        stb_n = 1'b0;
        repeat (w) tick();
        px_in = WIDTH'($urandom);
        stb_n = 1'b1;
        repeat (L) tick();
        if (!m_ibf) begin m_latch = d; m_ibf = 1'b1; end
        else m_ovr = 1'b1;
        if (m_ibf && inte) m_intr = 1'b1;
    endtask

    task automatic ack_pulse();
        ack_n = 1'b0;
        repeat (L) tick();
        ack_n = 1'b1;
        repeat (L) tick();
        m_obf_n = 1'b1;
        if (inte) m_intr = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        rst = 1'b1; mode = 2'b11; inte = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
        bus_rd = 1'b0; px_in = '0; stb_n = 1'b1; ack_n = 1'b1;
        m_mode = 2'b11; m_latch = '0; model_flush();

        // Reset with an output mode selected.
        tick(); tick();
        chk1("rst.px_oe", px_oe, 1'b0);
        chk1("rst.obf_n", obf_n, 1'b1);
        chk1("rst.ibf", ibf, 1'b0);
        chk1("rst.intr", intr, 1'b0);
        chk1("rst.ovr", ovr, 1'b0);
        chk8("rst.px_out", px_out, 8'h00);
        rst = 1'b0;
        tick();
        check_all("post_rst");

        // Mode 1 input: latency of ibf and intr.
        inte = 1'b1;
        set_mode(2'b10);
        check_all("m10.entry");
        px_in = 8'hA5;
        stb_n = 1'b0;
        repeat (L-1) tick();
        chk1("m10.ibf_early", ibf, 1'b0);
        tick();
        chk1("m10.ibf_set", ibf, 1'b1);
        chk8("m10.latch", bus_rdata, 8'hA5);
        stb_n = 1'b1;
        px_in = 8'h00;
        repeat (L-1) tick();
        chk1("m10.intr_early", intr, 1'b0);
        tick();
        chk1("m10.intr_set", intr, 1'b1);
        m_latch = 8'hA5; m_ibf = 1'b1; m_intr = 1'b1;
        check_all("m10.first");

        // Overrun: second strobe while full.
        stb_pulse(L, 8'h3C);
        check_all("m10.ovr");
        chk8("m10.ovr_keep", bus_rdata, 8'hA5);
        do_read();
        check_all("m10.read");

        // Read coincident with a strobe fall while full.
        stb_pulse(L + 1, 8'h11);
        d = WIDTH'($urandom);
        px_in = d;
        stb_n = 1'b0;
        repeat (L-1) tick();
        bus_rd = 1'b1;
        #1;
        chk8("coinc_rd.rdata", bus_rdata, 8'h11);
        tick();
        bus_rd = 1'b0;
        m_latch = d; m_ibf = 1'b1; m_ovr = 1'b0; m_intr = 1'b0;
        check_all("coinc_rd");
        stb_n = 1'b1;
        repeat (L) tick();
        m_intr = 1'b1;
        check_all("coinc_rd.rise");

        // Randomised Mode 1 input traffic, including inte toggling.
        for (int i = 0; i < 20; i++) begin
            inte = 1'($urandom);
            tick();
            if (!inte) m_intr = 1'b0;
            if ($urandom_range(2, 0) == 0) do_read();
            else stb_pulse(L + int'($urandom_range(3, 0)), WIDTH'($urandom));
            check_all("m10.rand");
        end

        // stb_n held low through reset must not load after release.
        rst = 1'b1; mode = 2'b10; stb_n = 1'b0; inte = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_mode = 2'b10; m_latch = '0; model_flush();
        repeat (2*L) tick();
        check_all("rst_stb_low");
        stb_n = 1'b1;
        repeat (L) tick();
        check_all("rst_stb_rise");

        // Mode 1 output.
        set_mode(2'b11);
        check_all("m11.entry");
        do_write(8'h5A);
        check_all("m11.write");
        ack_n = 1'b0;
        repeat (L-1) tick();
        chk1("m11.obf_early", obf_n, 1'b0);
        tick();
        chk1("m11.obf_fall", obf_n, 1'b1);
        ack_n = 1'b1;
        repeat (L-1) tick();
        chk1("m11.intr_early", intr, 1'b0);
        tick();
        chk1("m11.intr_rise", intr, 1'b1);
        m_obf_n = 1'b1; m_intr = 1'b1;
        check_all("m11.ack");
        do_write(WIDTH'($urandom));
        check_all("m11.write2");

        // Write coincident with the ack fall event.
        ack_pulse();
        d = WIDTH'($urandom);
        ack_n = 1'b0;
        repeat (L-1) tick();
        do_write(d);
        check_all("coinc_wr");
        ack_n = 1'b1;
        repeat (L) tick();
        check_all("coinc_wr.rise");

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1, 0) == 0) do_write(WIDTH'($urandom));
            else ack_pulse();
            check_all("m11.rand");
        end

        // Mode switch with intr pending, then with obf_n asserted.
        ack_pulse();
        do_write(8'h77);
        ack_pulse();
        check_all("pre_switch");
        set_mode(2'b10);
        check_all("switch.intr");
        set_mode(2'b11);
        do_write(8'h99);
        set_mode(2'b10);
        check_all("switch.obf");

        // Mode 0 input: unlatched pin read, writes ignored.
        set_mode(2'b00);
        for (int i = 0; i < 4; i++) begin
            px_in = WIDTH'($urandom);
            #1;
            chk8("m00.rdata", bus_rdata, px_in);
        end
        do_write(8'hC3);
        check_all("m00.wr_ignored");

        // Mode 0 output: write and readback.
        set_mode(2'b01);
        for (int i = 0; i < 4; i++) begin
            do_write(WIDTH'($urandom));
            check_all("m01.write");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
